// File: rtl/fixed_pkg.sv
// Signed Q16.16 fixed-point types and saturating arithmetic shared by the geometry pipeline.
package fixed_pkg;

  localparam int FIXED_WIDTH = 32;
  localparam int FIXED_FRAC  = 16;
  localparam int DIV_LATENCY = FIXED_WIDTH + 1;

  typedef logic signed [FIXED_WIDTH-1:0] fixed_t;

  localparam fixed_t FIXED_ONE = fixed_t'(1) <<< FIXED_FRAC;
  localparam fixed_t FIXED_MAX = fixed_t'({1'b0, {(FIXED_WIDTH-1){1'b1}}});
  localparam fixed_t FIXED_MIN = fixed_t'({1'b1, {(FIXED_WIDTH-1){1'b0}}});

  function automatic fixed_t to_fixed_int(input int i);
    return fixed_t'(i <<< FIXED_FRAC);
  endfunction

  // Clamp a double-width signed value into fixed_t range.
  function automatic fixed_t sat_wide(input logic signed [2*FIXED_WIDTH-1:0] v);
    logic [FIXED_WIDTH:0] hi;
    hi = v[2*FIXED_WIDTH-1:FIXED_WIDTH-1];
    if (hi == '0 || hi == '1) return fixed_t'(v[FIXED_WIDTH-1:0]);
    return v[2*FIXED_WIDTH-1] ? FIXED_MIN : FIXED_MAX;
  endfunction

  function automatic fixed_t mul(input fixed_t a, input fixed_t b);
    logic signed [2*FIXED_WIDTH-1:0] p;
    p = (2*FIXED_WIDTH)'(a) * (2*FIXED_WIDTH)'(b);
    p = p >>> FIXED_FRAC;
    return sat_wide(p);
  endfunction

  function automatic fixed_t add(input fixed_t a, input fixed_t b);
    logic signed [FIXED_WIDTH:0] s;
    s = (FIXED_WIDTH+1)'(a) + (FIXED_WIDTH+1)'(b);
    if (s[FIXED_WIDTH] != s[FIXED_WIDTH-1]) return s[FIXED_WIDTH] ? FIXED_MIN : FIXED_MAX;
    return fixed_t'(s[FIXED_WIDTH-1:0]);
  endfunction

  function automatic fixed_t sub(input fixed_t a, input fixed_t b);
    logic signed [FIXED_WIDTH:0] s;
    s = (FIXED_WIDTH+1)'(a) - (FIXED_WIDTH+1)'(b);
    if (s[FIXED_WIDTH] != s[FIXED_WIDTH-1]) return s[FIXED_WIDTH] ? FIXED_MIN : FIXED_MAX;
    return fixed_t'(s[FIXED_WIDTH-1:0]);
  endfunction

endpackage

// File: rtl/triangle_project_pkg.sv
// Projection-stage constants, FSM encoding and near-plane clamp helper.
package triangle_project_pkg;
  import fixed_pkg::*;

  localparam fixed_t Z_MIN = FIXED_ONE >>> 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_MUL,
    S_ADD,
    S_OUT
  } state_t;

  function automatic fixed_t clamp_z(input fixed_t z);
    return ($signed(z) < $signed(Z_MIN)) ? Z_MIN : z;
  endfunction

endpackage

// File: rtl/types_pkg.sv
// Geometry stream types passed between vertex transform, projection and triangle setup.
package types_pkg;
  import fixed_pkg::*;

  typedef struct packed {
    fixed_t      x;
    fixed_t      y;
    fixed_t      z;
    logic [23:0] color;
  } vertex_t;

  typedef struct packed {
    vertex_t [2:0] v;
  } triangle_t;

  typedef struct packed {
    logic last;
  } triangle_meta_t;

endpackage

// File: rtl/fixed_recip_div.sv
// Sequential reciprocal FIXED_ONE/divisor: radix-2 restoring, one quotient bit per cycle,
// DIV_LATENCY cycles from the start cycle to the done pulse; result saturates to +/-FIXED_MAX.
module fixed_recip_div
  import fixed_pkg::*;
(
  input  logic   clk,
  input  logic   rstn,
  input  logic   start,
  input  fixed_t divisor,
  output logic   done,
  output fixed_t quotient
);

  localparam int W  = FIXED_WIDTH;
  localparam int CW = $clog2(DIV_LATENCY + 1);
  // FIXED_ONE * FIXED_ONE in raw bits, so the integer quotient is already in fixed format.
  localparam logic [W:0] DIVIDEND = {{W{1'b0}}, 1'b1} << (2*FIXED_FRAC);

  logic          busy, neg, zdiv;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem, dmag;
  logic [W:0]    num, q;

  logic [W-1:0]  rem_in, d_in, rem_nx;
  logic [W:0]    num_in, trial;
  logic          ge;
  fixed_t        mag;

  // The start cycle already retires the first quotient bit from the fresh operands.
  always_comb begin
    rem_in = start ? '0 : rem;
    num_in = start ? DIVIDEND : num;
    d_in   = start ? (divisor[W-1] ? W'(-divisor) : W'(divisor)) : dmag;
    trial  = {rem_in, num_in[W]};
    ge     = trial >= {1'b0, d_in};
    rem_nx = ge ? W'(trial - {1'b0, d_in}) : trial[W-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      num  <= '0;
      q    <= '0;
      dmag <= '0;
      neg  <= 1'b0;
      zdiv <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= rem_nx;
        num  <= {num_in[W-1:0], 1'b0};
        q    <= {{W{1'b0}}, ge};
        dmag <= d_in;
        neg  <= divisor[W-1];
        zdiv <= (divisor == '0);
        cnt  <= CW'(DIV_LATENCY - 1);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= rem_nx;
        num <= {num_in[W-1:0], 1'b0};
        q   <= {q[W-1:0], ge};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    mag      = (zdiv || q[W:W-1] != 2'b00) ? FIXED_MAX : fixed_t'(q[W-1:0]);
    quotient = neg ? -mag : mag;
  end

endmodule

// File: rtl/triangle_project.sv
// Perspective projection of camera-space triangles to screen space using one shared divider.
// Optional near-plane culling: define TRIANGLE_PROJECT_CULL_NEAR_EN.
module triangle_project
  import fixed_pkg::*;
  import types_pkg::*;
  import triangle_project_pkg::*;
#(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int FOCAL    = 256
) (
  input  logic           clk,
  input  logic           rstn,
  input  triangle_t      triangle_s_data,
  input  triangle_meta_t triangle_s_metadata,
  input  logic           triangle_s_valid,
  output logic           triangle_s_ready,
  output triangle_t      triangle_m_data,
  output triangle_meta_t triangle_m_metadata,
  output logic           triangle_m_valid,
  input  logic           triangle_m_ready
);

  localparam fixed_t HALF_W_F = to_fixed_int(SCREEN_W / 2);
  localparam fixed_t HALF_H_F = to_fixed_int(SCREEN_H / 2);
  localparam fixed_t FOCAL_F  = to_fixed_int(FOCAL);

  state_t         state;
  logic [1:0]     vtx;
  triangle_t      tri_r;
  triangle_meta_t meta_r;
  fixed_t         inv_z, px, py;
  logic           div_start, div_done;
  fixed_t         div_q;
  vertex_t        cur_v;

  assign cur_v = tri_r.v[vtx];

  fixed_recip_div u_div (
    .clk      (clk),
    .rstn     (rstn),
    .start    (div_start),
    .divisor  (clamp_z(cur_v.z)),
    .done     (div_done),
    .quotient (div_q)
  );

`ifdef TRIANGLE_PROJECT_CULL_NEAR_EN
  logic near_hit;
  always_comb begin
    near_hit = 1'b0;
    for (int i = 0; i < 3; i++)
      if ($signed(triangle_s_data.v[i].z) < $signed(Z_MIN)) near_hit = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state               <= S_IDLE;
      vtx                 <= '0;
      tri_r               <= '0;
      meta_r              <= '0;
      inv_z               <= '0;
      px                  <= '0;
      py                  <= '0;
      div_start           <= 1'b0;
      triangle_s_ready    <= 1'b0;
      triangle_m_valid    <= 1'b0;
      triangle_m_data     <= '0;
      triangle_m_metadata <= '0;
    end else begin
      div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          triangle_s_ready <= 1'b1;
          if (triangle_s_valid && triangle_s_ready) begin
            tri_r  <= triangle_s_data;
            meta_r <= triangle_s_metadata;
            vtx    <= '0;
`ifdef TRIANGLE_PROJECT_CULL_NEAR_EN
            if (near_hit) begin
              // A culled frame-end triangle still has to carry the last marker downstream.
              if (triangle_s_metadata.last) begin
                triangle_m_data     <= '0;
                triangle_m_metadata <= triangle_s_metadata;
                triangle_m_valid    <= 1'b1;
                triangle_s_ready    <= 1'b0;
                state               <= S_OUT;
              end
            end else begin
              div_start        <= 1'b1;
              triangle_s_ready <= 1'b0;
              state            <= S_DIV;
            end
`else
            div_start        <= 1'b1;
            triangle_s_ready <= 1'b0;
            state            <= S_DIV;
`endif
          end
        end
        S_DIV: begin
          if (div_done) begin
            inv_z <= div_q;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          px    <= mul(cur_v.x, inv_z);
          py    <= mul(cur_v.y, inv_z);
          state <= S_ADD;
        end
        S_ADD: begin
          // Output register doubles as the assembly buffer; it is only observed once valid.
          triangle_m_data.v[vtx].x     <= add(HALF_W_F, mul(px, FOCAL_F));
          triangle_m_data.v[vtx].y     <= sub(HALF_H_F, mul(py, FOCAL_F));
          triangle_m_data.v[vtx].z     <= cur_v.z;
          triangle_m_data.v[vtx].color <= cur_v.color;
          if (vtx != 2'd2) begin
            vtx       <= vtx + 2'd1;
            div_start <= 1'b1;
            state     <= S_DIV;
          end else begin
            triangle_m_valid    <= 1'b1;
            triangle_m_metadata <= meta_r;
            state               <= S_OUT;
          end
        end
        S_OUT: begin
          if (triangle_m_valid && triangle_m_ready) begin
            triangle_m_valid <= 1'b0;
            triangle_s_ready <= 1'b1;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_project.sv
// Randomized self-checking bench for triangle_project against a plain-arithmetic projection model.
module tb_triangle_project;
  import fixed_pkg::*;
  import types_pkg::*;

  localparam int     LAT = 108;            // 3*(DIV_LATENCY+3), DIV_LATENCY = 33
  localparam longint ONE = 65536;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  triangle_t      s_data = '0;
  triangle_meta_t s_meta = '0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  triangle_t      m_data;
  triangle_meta_t m_meta;
  logic           m_valid;
  logic           m_ready = 1'b1;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  triangle_project dut (
    .clk                 (clk),
    .rstn                (rstn),
    .triangle_s_data     (s_data),
    .triangle_s_metadata (s_meta),
    .triangle_s_valid    (s_valid),
    .triangle_s_ready    (s_ready),
    .triangle_m_data     (m_data),
    .triangle_m_metadata (m_meta),
    .triangle_m_valid    (m_valid),
    .triangle_m_ready    (m_ready)
  );

  // ---------------- reference model ----------------
  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return sat32((a * b) >>> 16);
  endfunction

  function automatic triangle_t project(input triangle_t t);
    triangle_t r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      longint x, y, z, d, inv, px, py;
      x = longint'($signed(t.v[i].x));
      y = longint'($signed(t.v[i].y));
      z = longint'($signed(t.v[i].z));
      d = (z < ONE / 16) ? ONE / 16 : z;
      inv = sat32((64'sd1 <<< 32) / d);
      px = fmul(x, inv);
      py = fmul(y, inv);
      r.v[i].x     = fixed_t'(sat32(160 * ONE + fmul(px, 256 * ONE)));
      r.v[i].y     = fixed_t'(sat32(120 * ONE - fmul(py, 256 * ONE)));
      r.v[i].z     = t.v[i].z;
      r.v[i].color = t.v[i].color;
    end
    return r;
  endfunction

  function automatic triangle_t rand_tri();
    triangle_t t;
    for (int i = 0; i < 3; i++) begin
      t.v[i].x = fixed_t'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
      t.v[i].y = fixed_t'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
`ifdef TRIANGLE_PROJECT_CULL_NEAR_EN
      t.v[i].z = fixed_t'($urandom_range(4096, 16 * 65536));
`else
      t.v[i].z = fixed_t'(int'($urandom_range(0, 16 * 65536)) - 4096);
`endif
      t.v[i].color = 24'($urandom);
    end
    return t;
  endfunction

  // ---------------- handshake helpers ----------------
  task automatic push(input triangle_t t, input logic last, input bit keep, output int acc);
    acc = -1;
    s_data = t;
    s_meta.last = last;
    s_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (s_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (!keep) s_valid = 1'b0;
    if (acc < 0) begin
      n_chk++;
      $display("FAIL push_timeout: s_ready never high (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      if (m_valid === 1'b1) begin
        at = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (at < 0) begin
      n_chk++;
      $display("FAIL valid_timeout: m_valid never rose (cycle %0d)", cyc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({s_ready, m_valid} !== 2'b00) $display("FAIL reset_ctl: s_ready,m_valid=%b required 00", {s_ready, m_valid});
    else n_pass++;
    n_chk++;
    if (m_data !== '0 || m_meta !== '0) $display("FAIL reset_data: m_data=%h last=%b required zero", m_data, m_meta.last);
    else n_pass++;
    rstn = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (s_ready !== 1'b1) $display("FAIL reset_release: s_ready=%b required 1", s_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    triangle_t t;
    int acc, at;
    t.v[0].x = fixed_t'(ONE);      t.v[0].y = fixed_t'(ONE / 2); t.v[0].z = fixed_t'(2 * ONE); t.v[0].color = 24'hABCDEF;
    t.v[1].x = '0;                 t.v[1].y = '0;                t.v[1].z = fixed_t'(ONE);     t.v[1].color = 24'h123456;
    t.v[2].x = fixed_t'(-ONE);     t.v[2].y = fixed_t'(-ONE);    t.v[2].z = fixed_t'(4 * ONE); t.v[2].color = 24'h00FF00;
    push(t, 1'b1, 1'b0, acc);
    wait_valid(at);
    if (acc >= 0 && at >= 0) begin
      n_chk++;
      if (at - acc != LAT) $display("FAIL basic_latency: got %0d cycles required %0d", at - acc, LAT);
      else n_pass++;
    end
    n_chk++;
    if ({m_data.v[0].x, m_data.v[0].y, m_data.v[0].z} !== {fixed_t'(288 * ONE), fixed_t'(56 * ONE), fixed_t'(2 * ONE)})
      $display("FAIL basic_v0: got %h %h %h required 288,56,2", m_data.v[0].x, m_data.v[0].y, m_data.v[0].z);
    else n_pass++;
    n_chk++;
    if ({m_data.v[1].x, m_data.v[1].y, m_data.v[1].z} !== {fixed_t'(160 * ONE), fixed_t'(120 * ONE), fixed_t'(ONE)})
      $display("FAIL basic_v1: got %h %h %h required 160,120,1", m_data.v[1].x, m_data.v[1].y, m_data.v[1].z);
    else n_pass++;
    n_chk++;
    if ({m_data.v[2].x, m_data.v[2].y, m_data.v[2].z} !== {fixed_t'(96 * ONE), fixed_t'(184 * ONE), fixed_t'(4 * ONE)})
      $display("FAIL basic_v2: got %h %h %h required 96,184,4", m_data.v[2].x, m_data.v[2].y, m_data.v[2].z);
    else n_pass++;
    n_chk++;
    if ({m_data.v[0].color, m_data.v[1].color, m_data.v[2].color} !== {24'hABCDEF, 24'h123456, 24'h00FF00})
      $display("FAIL basic_color: got %h %h %h", m_data.v[0].color, m_data.v[1].color, m_data.v[2].color);
    else n_pass++;
    n_chk++;
    if (m_meta.last !== 1'b1) $display("FAIL basic_last: got %b required 1", m_meta.last);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    triangle_t t, exp;
    logic last;
    int acc, at;
    for (int k = 0; k < 6; k++) begin
      t = rand_tri();
      last = 1'($urandom);
      exp = project(t);
      push(t, last, 1'b0, acc);
      wait_valid(at);
      if (acc >= 0 && at >= 0) begin
        n_chk++;
        if (at - acc != LAT) $display("FAIL random_latency[%0d]: got %0d required %0d", k, at - acc, LAT);
        else n_pass++;
      end
      n_chk++;
      if (m_data !== exp || m_meta.last !== last)
        $display("FAIL random_data[%0d]: got %h/%b required %h/%b", k, m_data, m_meta.last, exp, last);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    triangle_t t, exp;
    int acc, at;
    t = rand_tri();
    exp = project(t);
    m_ready = 1'b0;
    push(t, 1'b0, 1'b0, acc);
    wait_valid(at);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== exp)
        $display("FAIL bp_hold[%0d]: valid=%b s_ready=%b data=%h required 1/0/%h", i, m_valid, s_ready, m_data, exp);
      else n_pass++;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL bp_release: valid=%b s_ready=%b required 0/1", m_valid, s_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    triangle_t t [4];
    triangle_t exp;
    int acc, at, prev_out;
    prev_out = -1;
    for (int k = 0; k < 4; k++) t[k] = rand_tri();
    for (int k = 0; k < 4; k++) begin
      push(t[k], 1'(k == 3), 1'b1, acc);
      exp = project(t[k]);
      wait_valid(at);
      if (k > 0 && acc >= 0 && prev_out >= 0) begin
        n_chk++;
        if (acc - prev_out != 2) $display("FAIL b2b_gap[%0d]: accept %0d cycles after prior valid, required 2", k, acc - prev_out);
        else n_pass++;
      end
      n_chk++;
      if (m_data !== exp || m_meta.last !== 1'(k == 3))
        $display("FAIL b2b_data[%0d]: got %h/%b required %h", k, m_data, m_meta.last, exp);
      else n_pass++;
      prev_out = at;
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    triangle_t t, exp;
    int acc, at;
    t = rand_tri();
    push(t, 1'b0, 1'b0, acc);
    repeat (40) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    n_chk++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0) $display("FAIL midrst_assert: valid=%b s_ready=%b required 0/0", m_valid, s_ready);
    else n_pass++;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) $display("FAIL midrst_release: valid=%b s_ready=%b required 0/1", m_valid, s_ready);
    else n_pass++;
    t = rand_tri();
    exp = project(t);
    push(t, 1'b1, 1'b0, acc);
    wait_valid(at);
    if (acc >= 0 && at >= 0) begin
      n_chk++;
      if (at - acc != LAT) $display("FAIL midrst_latency: got %0d required %0d", at - acc, LAT);
      else n_pass++;
    end
    n_chk++;
    if (m_data !== exp || m_meta.last !== 1'b1) $display("FAIL midrst_data: got %h required %h", m_data, exp);
    else n_pass++;
    @(posedge clk); #1;
  endtask

`ifdef TRIANGLE_PROJECT_CULL_NEAR_EN
  task automatic test_cull();
    triangle_t t;
    int acc, at, seen;
    t = rand_tri();
    t.v[1].z = fixed_t'(-ONE);
    push(t, 1'b0, 1'b0, acc);
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      if (m_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (seen != 0 || s_ready !== 1'b1) $display("FAIL cull_drop: valid cycles=%0d s_ready=%b required 0/1", seen, s_ready);
    else n_pass++;
    push(t, 1'b1, 1'b0, acc);
    wait_valid(at);
    n_chk++;
    if (m_data !== '0 || m_meta.last !== 1'b1) $display("FAIL cull_last: got %h/%b required 0/1", m_data, m_meta.last);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (m_valid !== 1'b0) $display("FAIL cull_last_xfer: valid=%b required 0", m_valid);
    else n_pass++;
  endtask
`else
  task automatic test_z_clamp();
    triangle_t t, exp;
    int acc, at;
    t = rand_tri();
    t.v[0].x = fixed_t'(100 * ONE);
    t.v[0].y = fixed_t'(-100 * ONE);
    t.v[0].z = '0;
    exp = project(t);
    push(t, 1'b0, 1'b0, acc);
    wait_valid(at);
    n_chk++;
    if ($isunknown(m_data) || m_data.v[0].x !== 32'sh7FFFFFFF || m_data.v[0].y !== 32'sh7FFFFFFF)
      $display("FAIL zclamp_sat: v0 x=%h y=%h required 7fffffff both", m_data.v[0].x, m_data.v[0].y);
    else n_pass++;
    n_chk++;
    if (m_data !== exp) $display("FAIL zclamp_data: got %h required %h", m_data, exp);
    else n_pass++;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef TRIANGLE_PROJECT_CULL_NEAR_EN
    test_cull();
`else
    test_z_clamp();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
